// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: drives one column at a time, assembles a 12-bit frame,
// and debounces whole frames into one key_valid pulse per press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  logic [3:0]       row_meta_reg, row_sync_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [1:0]       col_idx_reg;
  logic [3:0]       frame_slot_reg [2];
  logic [1:0]       state_reg, state_next;
  logic [3:0]       cand_reg, cand_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             tick, frame_close, accept, held_clr;
  logic [11:0]      frame_bits;
  logic [3:0]       hits;
  logic [3:0]       hit_code;
  logic             is_none, is_single;

  function automatic logic [3:0] key_map(input int r, input int c);
    if (r < 3) return 4'(3 * r + c + 1);
    case (c)
      0:       return 4'hA;
      1:       return 4'h0;
      default: return 4'hB;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_reg <= '0;
      row_sync_reg <= '0;
    end else begin
      row_meta_reg <= key_row;
      row_sync_reg <= row_meta_reg;
    end
  end

  assign tick        = (div_cnt_reg == DIV_MAX);
  assign frame_close = tick && (col_idx_reg == 2'd2);
  assign key_col     = 3'b001 << col_idx_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_reg <= '0;
      col_idx_reg <= 2'd0;
    end else begin
      div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
      if (tick) col_idx_reg <= (col_idx_reg == 2'd2) ? 2'd0 : col_idx_reg + 2'd1;
    end
  end

  // Column 2 is never stored: it is read live from the synchronizer on the closing tick.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) frame_slot_reg[gi] <= '0;
        else if (tick && col_idx_reg == 2'(gi)) frame_slot_reg[gi] <= row_sync_reg;
      end
    end
  endgenerate

  assign frame_bits = {row_sync_reg, frame_slot_reg[1], frame_slot_reg[0]};

  always_comb begin
    hits     = 4'd0;
    hit_code = 4'd0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (frame_bits[c * 4 + r]) begin
          hits     = hits + 4'd1;
          hit_code = key_map(r, c);
        end
      end
    end
  end

  assign is_none   = (hits == 4'd0);
  assign is_single = (hits == 4'd1);
  assign cnt_inc   = cnt_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    held_clr   = 1'b0;
    if (frame_close) begin
      case (state_reg)
        IDLE: begin
          if (is_single) begin
            cand_next = hit_code;
            cnt_next  = CNT_ONE;
            if (CNT_MAX == CNT_ONE) accept = 1'b1;
            else                    state_next = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (is_single) begin
            if (hit_code == cand_reg) begin
              cnt_next = cnt_inc;
              if (cnt_inc == CNT_MAX) accept = 1'b1;
            end else begin
              cand_next = hit_code;
              cnt_next  = CNT_ONE;
            end
          end else begin
            state_next = IDLE;
          end
        end
        PRESSED: begin
          if (is_none) begin
            cnt_next = CNT_ONE;
            if (CNT_MAX == CNT_ONE) begin
              held_clr   = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = RELEASE;
            end
          end
        end
        default: begin
          if (is_none) begin
            cnt_next = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              held_clr   = 1'b1;
              state_next = IDLE;
            end
          end else begin
            state_next = PRESSED;
          end
        end
      endcase
      if (accept) state_next = PRESSED;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cand_reg  <= 4'd0;
      cnt_reg   <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'hF;
      key_held  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      cnt_reg   <= cnt_next;
      key_valid <= accept;
      if (accept) begin
        key_code <= cand_next;
        key_held <= 1'b1;
      end else if (held_clr) begin
        key_held <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed keypad bench: a frame-level press/release model predicts
// accepted keys into a queue that a key_valid monitor drains and compares.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  logic [11:0] pressed = '0;  // bit r*3+c

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    key_row = '0;
    for (int r = 0; r < 4; r++) key_row[r] = |(pressed[r*3 +: 3] & key_col);
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  typedef struct { int frame; logic [3:0] code; } exp_t;
  exp_t exp_q[$];

  // Monitor: counts frame closes (column wraps 100 -> 001) and checks each pulse.
  int       frame_cnt  = 0;
  logic [2:0] prev_col = 3'b001;
  logic     prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_col   = 3'b001;
      prev_valid = 1'b0;
    end else begin
      if (prev_col == 3'b100 && key_col == 3'b001) frame_cnt++;
      prev_col = key_col;
      if (key_valid) begin
        check("pulse_width", {31'd0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_pulse: got code %0h at frame %0d expected no pulse", key_code, frame_cnt);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_frame", frame_cnt, e.frame);
          check("pulse_code", {28'd0, key_code}, {28'd0, e.code});
          $display("pulse frame %0d code %0h", frame_cnt, key_code);
        end
      end
      prev_valid = key_valid;
    end
  end

  // Reference model: operates on whole frames of pressed keys.
  logic       m_held = 1'b0;
  logic [3:0] m_code = 4'hF;
  logic [3:0] m_run_key = 4'h0;
  int         m_run  = 0;
  int         m_none = 0;

  function automatic logic [3:0] code_of(input int idx);
    int r, c;
    r = idx / 3;
    c = idx % 3;
    if (r < 3) return 4'(3 * r + c + 1);
    if (c == 0) return 4'hA;
    if (c == 1) return 4'h0;
    return 4'hB;
  endfunction

  task automatic model_frame(input logic [11:0] keys, input int fidx);
    int n;
    logic [3:0] k;
    n = $countones(keys);
    k = 4'h0;
    for (int i = 0; i < 12; i++) if (keys[i]) k = code_of(i);
    if (!m_held) begin
      if (n == 1) begin
        if (m_run > 0 && k == m_run_key) m_run++;
        else begin
          m_run_key = k;
          m_run     = 1;
        end
        if (m_run == DS) begin
          exp_t e;
          e.frame = fidx;
          e.code  = k;
          exp_q.push_back(e);
          m_held = 1'b1;
          m_code = k;
          m_none = 0;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (n == 0) begin
      m_none++;
      if (m_none == DS) begin
        m_held = 1'b0;
        m_run  = 0;
      end
    end else begin
      m_none = 0;
    end
  endtask

  task automatic wait_close(input int start);
    for (int i = 0; i < SD * 3 + 8 && frame_cnt == start; i++) begin
      @(negedge clk);
      #1;
    end
    compared++;
    if (frame_cnt == start) begin
      mismatched++;
      $display("FAIL frame_timeout: got no frame close after frame %0d expected one", start);
    end
  endtask

  task automatic run_frame(input logic [11:0] keys);
    int start;
    start   = frame_cnt;
    pressed = keys;
    model_frame(keys, start + 1);
    wait_close(start);
    check("key_held", {31'd0, key_held}, {31'd0, m_held});
    check("key_code", {28'd0, key_code}, {28'd0, m_code});
    $display("frame %0d keys %03h held %0b code %0h", frame_cnt, keys, key_held, key_code);
  endtask

  task automatic run_n(input logic [11:0] keys, input int n);
    for (int i = 0; i < n; i++) run_frame(keys);
  endtask

  task automatic do_reset(input logic [11:0] keys);
    @(posedge clk);
    #2;
    rst     = 1'b0;
    pressed = keys;
    m_held  = 1'b0;
    m_code  = 4'hF;
    m_run   = 0;
    m_none  = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_key_col", {29'd0, key_col}, 32'd1);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_code", {28'd0, key_code}, 32'hF);
    check("rst_key_held", {31'd0, key_held}, 32'd0);
    $display("reset applied, keys %03h", keys);
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  localparam logic [11:0] K5    = 12'h010;  // r1 c1
  localparam logic [11:0] K7    = 12'h040;  // r2 c0
  localparam logic [11:0] K1_3  = 12'h005;  // r0 c0 + r0 c2
  localparam logic [11:0] KHASH = 12'h800;  // r3 c2
  localparam logic [11:0] K2    = 12'h002;  // r0 c1
  localparam logic [11:0] K9    = 12'h100;  // r2 c2

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(12'h000);
    begin
      int start;
      logic [2:0] exp_col;
      start = frame_cnt;
      model_frame(12'h000, start + 1);
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        exp_col = 3'b001 << ((k / 4) % 3);
        check("col_cycle", {29'd0, key_col}, {29'd0, exp_col});
      end
      #1;
      check("first_frame", frame_cnt, start + 1);
    end

    run_n(K5, 6);
    run_n(12'h000, 4);

    run_n(K7, 2);
    run_n(12'h000, 1);
    run_n(K7, 2);
    run_n(12'h000, 2);

    run_n(K1_3, 5);
    run_n(12'h000, 1);

    run_n(KHASH, 4);
    run_n(KHASH | K2, 2);
    run_n(12'h000, 1);
    run_n(KHASH, 2);
    run_n(12'h000, 4);

    run_n(K9, 2);
    do_reset(K9);
    run_n(K9, 4);
    run_n(12'h000, 4);

    for (int s = 0; s < 30; s++) begin
      int kind, len, a, b;
      logic [11:0] keys;
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 5);
      a    = $urandom_range(0, 11);
      b    = (a + $urandom_range(1, 11)) % 12;
      keys = '0;
      if (kind == 1 || kind == 2) keys[a] = 1'b1;
      if (kind == 3) begin
        keys[a] = 1'b1;
        keys[b] = 1'b1;
      end
      run_n(keys, len);
    end
    run_n(12'h000, 4);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
